// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation path.
//   FMT_*   : 3-bit immediate-format select encodings
//   state_e : occupancy state of the two-entry output skid buffer
package imm_pkg;

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_U    = 3'b011;
    localparam logic [2:0] FMT_J    = 3'b100;
    localparam logic [2:0] FMT_Z    = 3'b101;
    localparam logic [2:0] FMT_SH   = 3'b110;
    localparam logic [2:0] FMT_RSVD = 3'b111;

    // EMPTY: nothing held; ONE: main register valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor / extender.
//   instr   : instruction bits [31:7] (opcode bits are never needed)
//   fmt     : format select (FMT_* in imm_pkg)
//   imm     : immediate extended to XLEN bits
//   illegal : fmt is the reserved encoding (imm forced to 0)
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Every format is first assembled as a 32-bit value already sign- or
    // zero-extended to 32 bits; widening to XLEN is then a plain sign
    // extension of bit 31 (zero-extended formats have bit 31 clear).
    logic [31:0] raw;

    always_comb begin
        // NOTE: defaults first so every path through the case assigns every
        // output; a missing assignment would infer a latch.
        raw     = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_I:  raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            FMT_U:  raw = {instr[31:12], 12'b0};
            FMT_J:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            FMT_Z:  raw = {27'b0, instr[19:15]};
            FMT_SH: raw = (XLEN == 64) ? {26'b0, instr[25:20]}
                                       : {27'b0, instr[24:20]};
            default: illegal = 1'b1;
        endcase
        imm = XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, valid/ready immediate generator with a two-entry skid buffer.
//   clk, rst                       : clock, async active-high reset
//   in_valid/in_ready              : upstream handshake
//   in_instr, in_fmt, in_tag       : instruction, format select, opaque tag
//   out_valid/out_ready            : downstream handshake
//   out_imm, out_illegal, out_tag  : registered decoded entry (main register)
// in_ready is a registered decode of the occupancy state, so it never
// depends combinationally on out_ready; the skid register absorbs the one
// extra instruction that can arrive in the cycle after out_ready drops.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_e          state_q;
    entry_t          m_q;
    entry_t          k_q;
    entry_t          entry_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            in_fire;
    logic            out_fire;
    logic            unused_opcode;

    // Opcode bits carry no immediate information.
    assign unused_opcode = ^in_instr[6:0];

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr[31:7]),
        .fmt     (in_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign entry_d  = '{imm: dec_imm, illegal: dec_illegal, tag: in_tag};
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset too because the outputs
            // must read zero after reset, not just be flagged invalid.
            state_q     <= EMPTY;
            m_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_q         <= entry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_q <= entry_d;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newcomer behind M.
                        k_q        <= entry_d;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_q        <= k_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = m_q.imm;
    assign out_illegal = m_q.illegal;
    assign out_tag     = m_q.tag;

endmodule
